// File: rtl/spi_ram_arbiter_if.sv
// ============================================================================
// Module : spi_ram_arbiter_if
// Brief  : Bus bundle for spi_ram_arbiter: two start/busy ports, controller link, status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spi_ram_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] a_addr;
    logic [DATA_BITS-1:0] a_data_in;
    logic                 a_start_read;
    logic                 a_start_write;
    logic [DATA_BITS-1:0] a_data_out;
    logic                 a_busy;

    logic [ADDR_BITS-1:0] b_addr;
    logic [DATA_BITS-1:0] b_data_in;
    logic                 b_start_read;
    logic                 b_start_write;
    logic [DATA_BITS-1:0] b_data_out;
    logic                 b_busy;

    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0] ram_data_in;
    logic                 ram_start_read;
    logic                 ram_start_write;
    logic [DATA_BITS-1:0] ram_data_out;
    logic                 ram_busy;

    logic                 owner;
    logic                 active;

    // Arbiter side
    modport slave (
        input  a_addr, a_data_in, a_start_read, a_start_write,
        output a_data_out, a_busy,
        input  b_addr, b_data_in, b_start_read, b_start_write,
        output b_data_out, b_busy,
        output ram_addr, ram_data_in, ram_start_read, ram_start_write,
        input  ram_data_out, ram_busy,
        output owner, active
    );

    // Requester / controller side
    modport master (
        output a_addr, a_data_in, a_start_read, a_start_write,
        input  a_data_out, a_busy,
        output b_addr, b_data_in, b_start_read, b_start_write,
        input  b_data_out, b_busy,
        input  ram_addr, ram_data_in, ram_start_read, ram_start_write,
        output ram_data_out, ram_busy,
        input  owner, active
    );
endinterface

`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
// ============================================================================
// Module : spi_ram_arbiter
// Brief  : Shares one spi_ram_controller between port A and port B.
//          Optional macro SPI_RAM_ARBITER_ROUND_ROBIN_EN selects round-robin grant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_ram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    spi_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ARMED = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 a_pend_q, a_wr_q, b_pend_q, b_wr_q;
    logic [ADDR_BITS-1:0] a_addr_q, b_addr_q, ram_addr_q;
    logic [DATA_BITS-1:0] a_wdata_q, b_wdata_q, ram_wdata_q;
    logic [DATA_BITS-1:0] a_dout_q, b_dout_q;
    logic                 owner_q, active_q, ram_rd_q, ram_wr_q;
    logic                 grant_d;
    logic                 done, a_done, b_done, owner_wr, grant_wr;

    assign done     = (state_q == ST_WAIT) && !bus.ram_busy;
    assign a_done   = done && !owner_q;
    assign b_done   = done &&  owner_q;
    assign owner_wr = owner_q ? b_wr_q : a_wr_q;
    assign grant_wr = grant_d ? b_wr_q : a_wr_q;

    // Request capture; a latched request is frozen until its transaction completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_pend_q  <= 1'b0;
            a_wr_q    <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
        end else if (a_done) begin
            a_pend_q <= 1'b0;
        end else if (!a_pend_q && (bus.a_start_read || bus.a_start_write)) begin
            a_pend_q  <= 1'b1;
            a_wr_q    <= bus.a_start_write;
            a_addr_q  <= bus.a_addr;
            a_wdata_q <= bus.a_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_pend_q  <= 1'b0;
            b_wr_q    <= 1'b0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
        end else if (b_done) begin
            b_pend_q <= 1'b0;
        end else if (!b_pend_q && (bus.b_start_read || bus.b_start_write)) begin
            b_pend_q  <= 1'b1;
            b_wr_q    <= bus.b_start_write;
            b_addr_q  <= bus.b_addr;
            b_wdata_q <= bus.b_data_in;
        end
    end

`ifdef SPI_RAM_ARBITER_ROUND_ROBIN_EN
    // Reset value B makes A the first winner of a tie.
    logic last_owner_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;
        end else if (done) begin
            last_owner_q <= owner_q;
        end
    end

    always_comb begin
        grant_d = b_pend_q;
        if (a_pend_q && b_pend_q) begin
            grant_d = ~last_owner_q;
        end
    end
`else
    always_comb begin
        grant_d = b_pend_q && !a_pend_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            active_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
        end else begin
            ram_rd_q <= 1'b0;
            ram_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (a_pend_q || b_pend_q) begin
                        owner_q     <= grant_d;
                        active_q    <= 1'b1;
                        ram_addr_q  <= grant_d ? b_addr_q  : a_addr_q;
                        ram_wdata_q <= grant_d ? b_wdata_q : a_wdata_q;
                        ram_wr_q    <= grant_wr;
                        ram_rd_q    <= ~grant_wr;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_ARMED;
                // Controller busy lags start by a cycle, so it is not trusted here.
                ST_ARMED: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (!bus.ram_busy) begin
                        if (!owner_wr && !owner_q) a_dout_q <= bus.ram_data_out;
                        if (!owner_wr &&  owner_q) b_dout_q <= bus.ram_data_out;
                        active_q    <= 1'b0;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_busy          = a_pend_q;
    assign bus.b_busy          = b_pend_q;
    assign bus.a_data_out      = a_dout_q;
    assign bus.b_data_out      = b_dout_q;
    assign bus.ram_addr        = ram_addr_q;
    assign bus.ram_data_in     = ram_wdata_q;
    assign bus.ram_start_read  = ram_rd_q & rst_n;
    assign bus.ram_start_write = ram_wr_q & rst_n;
    assign bus.owner           = owner_q;
    assign bus.active          = active_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
// ============================================================================
// Module : tb_spi_ram_arbiter
// Brief  : Self-checking bench for spi_ram_arbiter with a behavioural SPI RAM controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_ram_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus();
    spi_ram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- controller model ----------------
    logic [15:0] mem [int];
    int          ram_lat = 5;
    int          st = 0;
    int          cnt = 0;
    logic [15:0] rpend;

    function automatic logic [15:0] memval(logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.ram_busy     <= 1'b0;
            bus.ram_data_out <= 16'h0000;
            st <= 0;
        end else begin
            case (st)
                0: if (bus.ram_start_read || bus.ram_start_write) begin
                    st  <= 1;
                    cnt <= ram_lat;
                    if (bus.ram_start_write) begin
                        mem[int'(bus.ram_addr)] = bus.ram_data_in;
                        rpend <= 16'hDEAD;
                    end else begin
                        rpend <= memval(bus.ram_addr);
                    end
                end
                1: begin bus.ram_busy <= 1'b1; st <= 2; end
                default: begin
                    if (cnt <= 1) begin
                        bus.ram_busy     <= 1'b0;
                        bus.ram_data_out <= rpend;
                        st <= 0;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
            endcase
        end
    end

    // ---------------- transaction monitor ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        own;
        int          c;
    } txn_t;
    txn_t log_q[$];
    logic prev_start = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            checks++;
            if (bus.ram_start_read || bus.ram_start_write) begin
                failures++;
                $display("FAIL start_in_reset actual=%b%b required=00", bus.ram_start_read, bus.ram_start_write);
            end
        end else if (bus.ram_start_read || bus.ram_start_write) begin
            log_q.push_back('{wr: bus.ram_start_write, addr: bus.ram_addr, data: bus.ram_data_in,
                              own: bus.owner, c: cyc});
            checks++;
            if (prev_start || (bus.ram_start_read && bus.ram_start_write)) begin
                failures++;
                $display("FAIL start_pulse actual=prev%0b rd%0b wr%0b required=single one-cycle pulse",
                         prev_start, bus.ram_start_read, bus.ram_start_write);
            end
        end
        prev_start <= bus.ram_start_read | bus.ram_start_write;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_port(bit p, bit rd, bit wr, logic [15:0] addr, logic [15:0] d);
        if (!p) begin
            bus.a_addr = addr; bus.a_data_in = d; bus.a_start_read = rd; bus.a_start_write = wr;
        end else begin
            bus.b_addr = addr; bus.b_data_in = d; bus.b_start_read = rd; bus.b_start_write = wr;
        end
    endtask

    task automatic clear_starts();
        bus.a_start_read = 1'b0; bus.a_start_write = 1'b0;
        bus.b_start_read = 1'b0; bus.b_start_write = 1'b0;
    endtask

    function automatic logic port_busy(bit p);
        return p ? bus.b_busy : bus.a_busy;
    endfunction

    function automatic logic [15:0] port_dout(bit p);
        return p ? bus.b_data_out : bus.a_data_out;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_starts();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed single-transaction vectors ----------------
    typedef struct {
        bit          port;
        bit          wr;
        bit          both;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp_dout;
    } vec_t;

    task automatic run_vec(vec_t v, string nm);
        int   n0, n_start, fall;
        bit   other;
        txn_t t;
        n0 = log_q.size();
        @(negedge clk);
        ram_lat = v.lat;
        chk({nm, "_busy_before"}, port_busy(v.port), 0);
        drive_port(v.port, v.both | !v.wr, v.both | v.wr, v.addr, v.wdata);
        n_start = cyc;
        @(negedge clk);
        clear_starts();
        chk({nm, "_busy_n1"}, port_busy(v.port), 1);
        fall = -1;
        other = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (port_busy(!v.port)) other = 1'b1;
            if (!port_busy(v.port)) begin fall = cyc; break; end
            @(negedge clk);
        end
        chk({nm, "_completed"}, fall >= 0, 1);
        chk({nm, "_fall_cycle"}, fall, n_start + 5 + v.lat);
        chk({nm, "_ntxn"}, log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
            t = log_q[n0];
            chk({nm, "_ram_addr"}, t.addr, v.addr);
            chk({nm, "_ram_op"}, t.wr, v.wr | v.both);
            chk({nm, "_owner"}, t.own, v.port);
            chk({nm, "_start_cycle"}, t.c, n_start + 2);
            if (v.wr | v.both) chk({nm, "_ram_wdata"}, t.data, v.wdata);
        end
        chk({nm, "_dout"}, port_dout(v.port), v.exp_dout);
        chk({nm, "_other_busy"}, other, 0);
        chk({nm, "_idle_addr"}, bus.ram_addr, 0);
        chk({nm, "_idle_active"}, bus.active, 0);
    endtask

    task automatic dual(string nm, logic [15:0] aa, logic [15:0] ab,
                        logic [15:0] ea, logic [15:0] eb, bit exp_b_first);
        int n0, fa, fb;
        n0 = log_q.size();
        fa = -1;
        fb = -1;
        @(negedge clk);
        ram_lat = 3;
        drive_port(1'b0, 1'b1, 1'b0, aa, 16'h0);
        drive_port(1'b1, 1'b1, 1'b0, ab, 16'h0);
        @(negedge clk);
        clear_starts();
        for (int i = 0; i < 100; i++) begin
            if (fa < 0 && !bus.a_busy) fa = cyc;
            if (fb < 0 && !bus.b_busy) fb = cyc;
            if (fa >= 0 && fb >= 0) break;
            @(negedge clk);
        end
        chk({nm, "_completed"}, (fa >= 0) && (fb >= 0), 1);
        chk({nm, "_ntxn"}, log_q.size() - n0, 2);
        if (log_q.size() >= n0 + 2) begin
            chk({nm, "_first_owner"}, log_q[n0].own, exp_b_first);
            chk({nm, "_first_addr"}, log_q[n0].addr, exp_b_first ? ab : aa);
            chk({nm, "_second_owner"}, log_q[n0+1].own, !exp_b_first);
            chk({nm, "_second_addr"}, log_q[n0+1].addr, exp_b_first ? aa : ab);
        end
        chk({nm, "_fall_order"}, exp_b_first ? (fb < fa) : (fa < fb), 1);
        chk({nm, "_a_dout"}, bus.a_data_out, ea);
        chk({nm, "_b_dout"}, bus.b_data_out, eb);
    endtask

    // ---------------- random scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;
    req_t        qa[$], qb[$];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_da, exp_db, next_da, next_db;
    bit          prev_ab, prev_bb, iss_a, iss_b;
    int          sb_idx;

    function automatic logic [15:0] ref_val(logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    task automatic rnd_issue(bit p, output req_t r);
        bit both;
        r.wr   = 1'($urandom_range(0, 1));
        r.addr = 16'h0300 + 16'($urandom_range(0, 7));
        r.data = 16'($urandom);
        both   = r.wr && ($urandom_range(0, 3) == 0);
        drive_port(p, both | !r.wr, r.wr, r.addr, r.data);
    endtask

    task automatic rnd_step(bit allow);
        txn_t        t;
        req_t        r;
        logic [15:0] ev;
        @(negedge clk);
        while (sb_idx < log_q.size()) begin
            t = log_q[sb_idx];
            sb_idx++;
            checks++;
            if ((t.own ? qb.size() : qa.size()) == 0) begin
                failures++;
                $display("FAIL rnd_unexpected_txn actual=owner %0d addr 0x%0h required=no transaction", t.own, t.addr);
            end else begin
                r = t.own ? qb.pop_front() : qa.pop_front();
                chk("rnd_op", t.wr, r.wr);
                chk("rnd_addr", t.addr, r.addr);
                if (r.wr) begin
                    chk("rnd_wdata", t.data, r.data);
                    ref_mem[int'(r.addr)] = r.data;
                    ev = t.own ? exp_db : exp_da;
                end else begin
                    ev = ref_val(r.addr);
                end
                if (t.own) next_db = ev; else next_da = ev;
            end
        end
        if (iss_a) chk("rnd_a_busy_next", bus.a_busy, 1);
        if (iss_b) chk("rnd_b_busy_next", bus.b_busy, 1);
        if (prev_ab && !bus.a_busy) begin chk("rnd_a_dout", bus.a_data_out, next_da); exp_da = next_da; end
        if (prev_bb && !bus.b_busy) begin chk("rnd_b_dout", bus.b_data_out, next_db); exp_db = next_db; end
        clear_starts();
        iss_a = 1'b0;
        iss_b = 1'b0;
        if (allow) begin
            ram_lat = $urandom_range(1, 4);
            if (!bus.a_busy && $urandom_range(0, 2) == 0) begin
                rnd_issue(1'b0, r); qa.push_back(r); iss_a = 1'b1;
            end else if (bus.a_busy && $urandom_range(0, 7) == 0) begin
                drive_port(1'b0, 1'b1, 1'b0, 16'h0F00, 16'h0);
            end
            if (!bus.b_busy && $urandom_range(0, 2) == 0) begin
                rnd_issue(1'b1, r); qb.push_back(r); iss_b = 1'b1;
            end else if (bus.b_busy && $urandom_range(0, 7) == 0) begin
                drive_port(1'b1, 1'b0, 1'b1, 16'h0F01, 16'hFFFF);
            end
        end
        prev_ab = bus.a_busy;
        prev_bb = bus.b_busy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vt [10];
        int   n0, a_sent;
        logic [2:0] owners;

        vt[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 5, 16'hBEEF};
        vt[1] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h1234, 3, 16'h0000};
        vt[2] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 2, 16'h1234};
        vt[3] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h5555, 1, 16'hBEEF};
        vt[4] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'h5555};
        vt[5] = '{1'b0, 1'b0, 1'b0, 16'h0077, 16'h0000, 1, 16'h5A2D};
        vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 6, 16'h5555};
        vt[7] = '{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 2, 16'h1234};
        vt[8] = '{1'b1, 1'b0, 1'b1, 16'h0200, 16'hCAFE, 2, 16'h5555};
        vt[9] = '{1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 3, 16'hCAFE};

        bus.a_addr = '0; bus.a_data_in = '0;
        bus.b_addr = '0; bus.b_data_in = '0;
        clear_starts();
        bus.a_start_read = 1'b1;   // must be ignored while in reset

        repeat (3) @(negedge clk);
        chk("rst_a_busy", bus.a_busy, 0);
        chk("rst_b_busy", bus.b_busy, 0);
        chk("rst_a_dout", bus.a_data_out, 0);
        chk("rst_b_dout", bus.b_data_out, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        rst_n = 1'b1;
        clear_starts();
        @(negedge clk);
        chk("post_rst_a_busy", bus.a_busy, 0);
        chk("post_rst_ntxn", log_q.size(), 0);

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Simultaneous requests straight after reset: A wins under either policy.
        do_reset();
        dual("dual_rst", 16'h0020, 16'h0030, 16'h5A7A, 16'h5A6A, 1'b0);

        // Tie after an A-only transaction: round-robin now favours B.
        run_vec('{1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1, 16'h5A1A}, "pre_tie");
`ifdef SPI_RAM_ARBITER_ROUND_ROBIN_EN
        dual("dual_tie", 16'h0050, 16'h0060, 16'h5A0A, 16'h5A3A, 1'b1);
`else
        dual("dual_tie", 16'h0050, 16'h0060, 16'h5A0A, 16'h5A3A, 1'b0);
`endif

        // A re-requests the moment its busy drops while B waits: grants A, B, A.
        do_reset();
        n0 = log_q.size();
        @(negedge clk);
        ram_lat = 3;
        drive_port(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
        a_sent = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            clear_starts();
            if (a_sent == 2 && !bus.a_busy && !bus.b_busy) break;
            if (a_sent < 2 && !bus.a_busy) begin
                drive_port(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
                a_sent++;
            end
        end
        chk("rr_ntxn", log_q.size() - n0, 3);
        if (log_q.size() >= n0 + 3) begin
            owners = {log_q[n0].own, log_q[n0+1].own, log_q[n0+2].own};
            chk("rr_grant_order", owners, 3'b010);
        end

        // Second start while busy is dropped.
        n0 = log_q.size();
        @(negedge clk);
        ram_lat = 4;
        drive_port(1'b0, 1'b1, 1'b0, 16'h0090, 16'h0);
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 16'h0091, 16'h0);
        @(negedge clk);
        clear_starts();
        for (int i = 0; i < 60; i++) begin
            if (!bus.a_busy) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("drop_ntxn", log_q.size() - n0, 1);
        if (log_q.size() > n0) chk("drop_addr", log_q[n0].addr, 16'h0090);
        chk("drop_dout", bus.a_data_out, 16'h5ACA);
        chk("drop_busy", bus.a_busy, 0);

        // Reset while the controller is busy aborts everything.
        n0 = log_q.size();
        @(negedge clk);
        ram_lat = 10;
        drive_port(1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0);
        @(negedge clk);
        clear_starts();
        drive_port(1'b1, 1'b1, 1'b0, 16'h00B0, 16'h0);
        @(negedge clk);
        clear_starts();
        for (int i = 0; i < 20; i++) begin
            if (log_q.size() > n0) break;
            @(negedge clk);
        end
        chk("abort_started", log_q.size() - n0, 1);
        repeat (3) @(negedge clk);
        chk("abort_in_wait", bus.active, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_a_busy", bus.a_busy, 0);
        chk("abort_b_busy", bus.b_busy, 0);
        chk("abort_active", bus.active, 0);
        chk("abort_a_dout", bus.a_data_out, 0);
        chk("abort_b_dout", bus.b_data_out, 0);
        rst_n = 1'b1;
        n0 = log_q.size();
        repeat (20) @(negedge clk);
        chk("abort_no_start", log_q.size() - n0, 0);

        // Randomised traffic against the scoreboard.
        do_reset();
        qa.delete();
        qb.delete();
        exp_da = '0; exp_db = '0; next_da = '0; next_db = '0;
        prev_ab = 1'b0; prev_bb = 1'b0; iss_a = 1'b0; iss_b = 1'b0;
        sb_idx = log_q.size();
        for (int i = 0; i < 600; i++) rnd_step(1'b1);
        for (int i = 0; i < 200; i++) begin
            rnd_step(1'b0);
            if (!bus.a_busy && !bus.b_busy && !prev_ab && !prev_bb) break;
        end
        rnd_step(1'b0);
        chk("rnd_qa_drained", qa.size(), 0);
        chk("rnd_qb_drained", qb.size(), 0);
        chk("rnd_log_consumed", log_q.size() - sb_idx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Two-port arbiter that shares the single spi_ram_controller between the CPU (port A) and a second master (port B), such as a debug loader or DMA engine. Each port sees the same start/busy/data interface the CPU already uses with the RAM controller. The block latches requests, serialises them onto the controller, and returns read data on the owning port.

Parameters:
ADDR_BITS, 16, width of address on all ports
DATA_BITS, 16, width of data on all ports

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
a_addr  in  ADDR_BITS  port A address
a_data_in  in  DATA_BITS  port A write data
a_start_read  in  1  port A read request pulse
a_start_write  in  1  port A write request pulse
a_data_out  out  DATA_BITS  port A read data, registered
a_busy  out  1  port A request outstanding
b_addr, b_data_in, b_start_read, b_start_write, b_data_out, b_busy  same as port A, for port B
ram_addr  out  ADDR_BITS  to controller addr_in
ram_data_in  out  DATA_BITS  to controller data_in
ram_start_read  out  1  to controller start_read
ram_start_write  out  1  to controller start_write
ram_data_out  in  DATA_BITS  from controller data_out
ram_busy  in  1  from controller busy
owner  out  1  port being served: 0 = A, 1 = B; valid while active
active  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at posedge): FSM to IDLE; pending flags, a_busy, b_busy, a_data_out, b_data_out, owner and active all 0. ram_start_* are 0 during reset.
- Reset mid-transaction aborts the transaction and drops any latched request. The controller shares rst_n.
- Capture, per port, independently:
  - If start_read or start_write is high and x_busy is 0, latch addr, data_in and op into the pending registers, set the pending flag, and set x_busy=1 from the next cycle.
  - If both start_read and start_write are high, the request is a write.
  - A start pulse while x_busy=1 is ignored and dropped.
- FSM states: IDLE, ISSUE, ARMED, WAIT.
  - IDLE: if any pending flag is set, select a port by the arbitration policy, register it in owner, go to ISSUE. Otherwise stay.
  - ISSUE: drive ram_addr and ram_data_in from the owner's pending registers. Pulse ram_start_read or ram_start_write high for exactly this one cycle. Go to ARMED.
  - ARMED: ignore ram_busy, because the controller's busy rises one cycle late. Go to WAIT.
  - WAIT: when ram_busy=0, the transaction completes:
    - read: owner's x_data_out <= ram_data_out;
    - write: x_data_out is unchanged;
    - clear the owner's pending flag, x_busy <= 0, go to IDLE.
- Outside ISSUE, ram_start_* = 0. ram_addr and ram_data_in keep driving the owner's pending values while active, and are 0 in IDLE.
- Latency: start pulse at cycle N gives x_busy=1 at N+1 and ram_start at N+2 at the earliest. x_busy falls, and x_data_out is valid, in the cycle after ram_busy is sampled low in WAIT.
- x_busy is high in the cycle after the start pulse. This satisfies the CPU, which samples busy one cycle after issuing start.
- A port may issue a new start in the same cycle its x_busy reads 0.
- A new request from the non-owner port is latched while the owner's transaction is in flight, and is served next.
- Arbitration (default, fixed priority): when both ports are pending in IDLE, A wins. B can starve under continuous A traffic; this is accepted.
- Pending registers are never overwritten while their flag is set.

Optional Feature:
SPI_RAM_ARBITER_ROUND_ROBIN_EN:
- Defined: a last_owner register, reset to 1 (B) so A is granted first. When both ports are pending, the port != last_owner is granted. last_owner updates when a transaction completes. With only one port pending, that port is granted.
- Undefined: fixed priority, A over B; no last_owner register.

Test Plan:
1. A read @0x0010; RAM model busy 5 cycles, data 0xBEEF -> ram_start_read high exactly one cycle at N+2 with ram_addr=0x0010; a_busy high from N+1; a_data_out=0xBEEF when a_busy falls; b_busy stays 0.
2. B write 0x1234 @0x0100 -> a single ram_start_write with ram_data_in=0x1234, owner=1; b_data_out remains 0.
3. A read @0x0020 and B read @0x0030 in the same cycle (fixed priority) -> controller sees 0x0020 then 0x0030; a_busy falls before b_busy; each port gets its own data.
4. ROUND_ROBIN_EN defined; A re-requests every time a_busy drops while B has a read pending -> grant order A, B, A; B is not starved.
5. rst_n low during WAIT of an A read -> next cycle a_busy, b_busy, active and data_out are all 0; no ram_start pulse until a new request arrives.
6. A start_read, then a second A start_read while a_busy=1 -> exactly one controller transaction.
